// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and constants for the nibble-serial adder.
package arith_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int NIBBLE_W = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: request/result handshake bundle for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
    logic         busy;
    modport master (output in_valid, a, b, sub, out_ready,
                    input  in_ready, out_valid, sum, carryout, overflow, busy);
    modport slave  (input  in_valid, a, b, sub, out_ready,
                    output in_ready, out_valid, sum, carryout, overflow, busy);
endinterface

// File: rtl/adder_slice4.sv
// adder_slice4: combinational 4-bit ripple adder; c3 is the carry into bit 3 for overflow.
module adder_slice4 (
    output logic [3:0] sum,
    output logic       carryout,
    output logic       c3,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carryin
);
    logic [4:0] c;
    always_comb begin
        c[0] = carryin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign carryout = c[4];
    assign c3       = c[3];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: runs a W-bit add/subtract through one 4-bit slice, LSB nibble first.
module nibble_serial_add_ctrl
    import arith_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     reset,
    nibble_serial_add_ctrl_if.slave io
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      s_sum;
    logic            s_co, s_c3, accept;

    adder_slice4 u_slice (
        .sum      (s_sum),
        .carryout (s_co),
        .c3       (s_c3),
        .a        (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b        (b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q == OP_SUB}}),
        .carryin  (carry_q)
    );

    // DONE with a simultaneous handshake and new request chains straight into RUN
    assign accept = io.in_valid & (state_q == IDLE | (state_q == DONE & io.out_ready));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            state_d = RUN;
            a_d     = io.a;
            b_d     = io.b;
            sub_d   = io.sub;
            idx_d   = '0;
            carry_d = io.sub;
        end else if (state_q == DONE && io.out_ready) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_sum;
            carry_d = s_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NIBBLES - 1)) begin
                idx_d   = '0;
                cout_d  = s_co;
                ovf_d   = s_c3 ^ s_co;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign io.in_ready  = state_q == IDLE || (state_q == DONE && io.out_ready);
    assign io.out_valid = state_q == DONE;
    assign io.busy      = state_q == RUN;
    assign io.sum       = sum_q;
    assign io.carryout  = cout_q;
    assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed vectors for the nibble-serial adder at NIBBLES=4.
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    nibble_serial_add_ctrl_if #(.NIBBLES(4)) io ();

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid, scrambling inputs meanwhile.
    task automatic wait_result(input string tag);
        int n = 1;
        while (!io.out_valid && n < 20) begin
            io.a   = 16'($urandom);
            io.b   = 16'($urandom);
            io.sub = 1'($urandom);
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd5);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        int w = 0;
        while (!io.in_ready && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_rdy"}, 32'(io.in_ready), 32'd1);
        io.a = a;
        io.b = b;
        io.sub = sub;
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        wait_result(tag);
        chk({tag, "_sum"}, 32'(io.sum), 32'(es));
        chk({tag, "_c"}, 32'(io.carryout), 32'(ec));
        chk({tag, "_v"}, 32'(io.overflow), 32'(eo));
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(io.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.a = '0;
        io.b = '0;
        io.sub = 1'b0;
        #2;
        chk("rst_rdy", 32'(io.in_ready), 32'd1);
        chk("rst_ov", 32'(io.out_valid), 32'd0);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_sum", 32'(io.sum), 32'd0);
        chk("rst_c", 32'(io.carryout), 32'd0);
        chk("rst_v", 32'(io.overflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_op("add1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("addov", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("addc", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        run_op("sub1", 16'h0005, 16'h000C, 1'b1, 16'hFFF9, 1'b0, 1'b0);
        run_op("subov", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure then back-to-back
        io.a = 16'h0100;
        io.b = 16'h0023;
        io.sub = 1'b0;
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        wait_result("bp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", 32'(io.sum), 32'h0123);
            chk("bp_rdy", 32'(io.in_ready), 32'd0);
            chk("bp_ov", 32'(io.out_valid), 32'd1);
            tick();
        end
        io.a = 16'h1234;
        io.b = 16'h1111;
        io.sub = 1'b0;
        io.in_valid = 1'b1;
        io.out_ready = 1'b1;
        #1;
        chk("b2b_rdy", 32'(io.in_ready), 32'd1);
        tick();
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        chk("b2b_busy", 32'(io.busy), 32'd1);
        wait_result("b2b");
        chk("b2b_sum", 32'(io.sum), 32'h2345);
        chk("b2b_c", 32'(io.carryout), 32'd0);
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;

        // Reset two cycles into RUN
        io.a = 16'h4444;
        io.b = 16'h3333;
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_ov", 32'(io.out_valid), 32'd0);
        chk("mid_busy", 32'(io.busy), 32'd0);
        chk("mid_rdy", 32'(io.in_ready), 32'd1);
        chk("mid_sum", 32'(io.sum), 32'd0);
        chk("mid_c", 32'(io.carryout), 32'd0);
        chk("mid_v", 32'(io.overflow), 32'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (io.out_valid) seen++;
            tick();
        end
        chk("mid_nopulse", 32'(seen), 32'd0);

        run_op("fresh", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
